// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared definitions for the MIPS pipeline decode logic: opcode
//            constants, ALU operation classes, the decoded-control record and
//            the ID-stage state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_J     = 6'h02;

  // ALU operation class handed to EX; FUNCT means "look at instr[5:0]"
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_SLT   = 3'd2;
  localparam logic [2:0] ALU_FUNCT = 3'd3;

  // Decoded control for one instruction. regdst selects rd as destination,
  // uses_rt marks instructions that actually read rt as a source operand.
  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       regdst;
    logic       uses_rt;
    logic [2:0] aluop;
  } ctrl_t;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } id_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/id_ex_stage_control_decode.sv
`default_nettype none
// ============================================================================
// Module   : control_decode
// Purpose  : Purely combinational opcode-to-control decoder. Unknown opcodes
//            decode to all-zero control (a NOP).
// Ports    : opcode_i - instruction opcode field instr[31:26]
//            ctrl_o   - decoded control record
// Revision : 1.0 - initial release
// ============================================================================
module control_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
        ctrl_o.uses_rt  = 1'b1;
        ctrl_o.aluop    = ALU_FUNCT;
      end
      OP_LW: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memread  = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.aluop    = ALU_ADD;
      end
      OP_SW: begin
        ctrl_o.memwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.uses_rt  = 1'b1;
        ctrl_o.aluop    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch  = 1'b1;
        ctrl_o.uses_rt = 1'b1;
        ctrl_o.aluop   = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.aluop    = ALU_ADD;
      end
      OP_SLTI: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.aluop    = ALU_SLT;
      end
      OP_J: begin
        ctrl_o.jump = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule : control_decode
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : MIPS decode stage plus the ID/EX pipeline register. Drives the
//            register-file read addresses, decodes control, bypasses
//            same-cycle writeback data, detects load-use hazards (one bubble
//            each) and counts inserted bubbles with a saturating counter.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            instr, pc4          - IF/ID contents
//            flush               - squash the instruction currently in ID
//            r1, r2              - register-file read addresses (comb)
//            rdata1, rdata2      - register-file read data
//            wb_regwrite/w/wdata - writeback port, used for bypassing
//            stall               - hold PC and IF/ID (comb)
//            ex_*                - registered ID/EX contents
//            stall_count         - saturating bubble count
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instr,
  input  logic [WIDTH-1:0] pc4,
  input  logic             flush,
  output logic [RA_W-1:0]  r1,
  output logic [RA_W-1:0]  r2,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  input  logic             wb_regwrite,
  input  logic [RA_W-1:0]  wb_w,
  input  logic [WIDTH-1:0] wb_wdata,
  output logic             stall,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_alusrc,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [2:0]       ex_aluop,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [WIDTH-1:0] ex_imm,
  output logic [RA_W-1:0]  ex_rs,
  output logic [RA_W-1:0]  ex_rt,
  output logic [RA_W-1:0]  ex_wr,
  output logic [WIDTH-1:0] ex_pc4,
  output logic [CNT_W-1:0] stall_count
);

  ctrl_t           dec;
  logic [RA_W-1:0] rd_addr;
  logic            hz;

  // Next-state (normally captured) values for the ID/EX register
  logic             regwrite_d;
  logic [RA_W-1:0]  wr_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] imm_d;

  // Registered state
  id_state_e        state_q;
  ctrl_t            ctrl_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] imm_q;
  logic [RA_W-1:0]  rs_q;
  logic [RA_W-1:0]  rt_q;
  logic [RA_W-1:0]  wr_q;
  logic [WIDTH-1:0] pc4_q;
  logic [CNT_W-1:0] stall_count_q;

  control_decode u_control_decode (
    .opcode_i (instr[31:26]),
    .ctrl_o   (dec)
  );

  assign r1      = instr[21 +: RA_W];
  assign r2      = instr[16 +: RA_W];
  assign rd_addr = instr[11 +: RA_W];

  always_comb begin
    // All-zero word is sll $0,$0,0; it must not count as a register write.
    regwrite_d = dec.regwrite & (instr != '0);

    if (dec.regdst)
      wr_d = rd_addr;
    else if (dec.regwrite)
      wr_d = r2;
    else
      wr_d = '0;

    // The register file writes on posedge but was read on the preceding
    // negedge, so a same-cycle writeback must be forwarded here.
    if (wb_regwrite && (wb_w != '0) && (wb_w == r1))
      a_d = wb_wdata;
    else
      a_d = rdata1;

    if (wb_regwrite && (wb_w != '0) && (wb_w == r2))
      b_d = wb_wdata;
    else
      b_d = rdata2;

    imm_d = {{(WIDTH-16){instr[15]}}, instr[15:0]};
  end

  // Load-use: the load in EX has not produced its data yet.
  assign hz    = ctrl_q.memread && (wr_q != '0) &&
                 ((wr_q == r1) || ((wr_q == r2) && dec.uses_rt));
  assign stall = hz && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      ctrl_q        <= '0;
      a_q           <= '0;
      b_q           <= '0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      wr_q          <= '0;
      pc4_q         <= '0;
      stall_count_q <= '0;
    end else begin
      if (stall && !(&stall_count_q))
        stall_count_q <= stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

      // In BUBBLE the EX slot holds a bubble, so hz cannot fire there.
      case (state_q)
        RUN:     state_q <= stall ? BUBBLE : RUN;
        BUBBLE:  state_q <= RUN;
        default: state_q <= RUN;
      endcase

      if (flush || stall) begin
        ctrl_q <= '0;
        a_q    <= '0;
        b_q    <= '0;
        imm_q  <= '0;
        rs_q   <= '0;
        rt_q   <= '0;
        wr_q   <= '0;
        pc4_q  <= '0;
      end else begin
        ctrl_q          <= dec;
        ctrl_q.regwrite <= regwrite_d;
        a_q             <= a_d;
        b_q             <= b_d;
        imm_q           <= imm_d;
        rs_q            <= r1;
        rt_q            <= r2;
        wr_q            <= wr_d;
        pc4_q           <= pc4;
      end
    end
  end

  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_branch   = ctrl_q.branch;
  assign ex_jump     = ctrl_q.jump;
  assign ex_aluop    = ctrl_q.aluop;
  assign ex_a        = a_q;
  assign ex_b        = b_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_wr       = wr_q;
  assign ex_pc4      = pc4_q;
  assign stall_count = stall_count_q;

  // regdst/uses_rt are consumed in ID only; state is kept for debug.
  logic unused_ok;
  assign unused_ok = &{1'b0, ctrl_q.regdst, ctrl_q.uses_rt, state_q};

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage. Expected ID/EX contents are
//            produced by a small reference decoder, queued when stimulus is
//            applied and compared when the register updates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int WIDTH = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] instr, pc4, rdata1, rdata2, wb_wdata;
  logic             flush, wb_regwrite;
  logic [RA_W-1:0]  wb_w, r1, r2;
  logic             stall;
  logic             ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic             ex_alusrc, ex_branch, ex_jump;
  logic [2:0]       ex_aluop;
  logic [WIDTH-1:0] ex_a, ex_b, ex_imm, ex_pc4;
  logic [RA_W-1:0]  ex_rs, ex_rt, ex_wr;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(WIDTH), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .pc4(pc4), .flush(flush),
    .r1(r1), .r2(r2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_regwrite(wb_regwrite), .wb_w(wb_w), .wb_wdata(wb_wdata),
    .stall(stall),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_aluop(ex_aluop), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr(ex_wr), .ex_pc4(ex_pc4),
    .stall_count(stall_count)
  );

  // ctrl = {regwrite, memread, memwrite, memtoreg, alusrc, branch, jump, aluop[2:0]}
  typedef struct packed {
    logic [9:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [14:0] regs;  // {rs, rt, wr}
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic       m_memread;
  logic [4:0] m_wr;
  int         m_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] p4,
                                     input logic [31:0] rd1, input logic [31:0] rd2,
                                     input logic wre, input logic [4:0] ww,
                                     input logic [31:0] wd);
    exp_t e;
    logic rw, mr, mw, mt, as, br, jp;
    logic [2:0] op3;
    logic [4:0] wr;
    {rw, mr, mw, mt, as, br, jp} = '0;
    op3 = 3'd0;
    wr  = 5'd0;
    case (ins[31:26])
      6'h00: begin rw = (ins != 32'h0); op3 = 3'd3; wr = ins[15:11]; end
      6'h23: begin rw = 1; mr = 1; mt = 1; as = 1; wr = ins[20:16]; end
      6'h2B: begin mw = 1; as = 1; end
      6'h04: begin br = 1; op3 = 3'd1; end
      6'h08: begin rw = 1; as = 1; wr = ins[20:16]; end
      6'h0A: begin rw = 1; as = 1; op3 = 3'd2; wr = ins[20:16]; end
      6'h02: begin jp = 1; end
      default: ;
    endcase
    e.ctrl = {rw, mr, mw, mt, as, br, jp, op3};
    e.a    = (wre && ww != 0 && ww == ins[25:21]) ? wd : rd1;
    e.b    = (wre && ww != 0 && ww == ins[20:16]) ? wd : rd2;
    e.imm  = {{16{ins[15]}}, ins[15:0]};
    e.regs = {ins[25:21], ins[20:16], wr};
    e.pc4  = p4;
    return e;
  endfunction

  // Called one time unit after a posedge; returns one time unit after the next.
  task automatic step(input logic [31:0] ins, input logic [31:0] p4,
                      input logic [31:0] rd1, input logic [31:0] rd2,
                      input logic wre, input logic [4:0] ww, input logic [31:0] wd,
                      input logic fl);
    logic ut, hzx, st;
    exp_t e, got;
    instr = ins; pc4 = p4; rdata1 = rd1; rdata2 = rd2;
    wb_regwrite = wre; wb_w = ww; wb_wdata = wd; flush = fl;
    ut  = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
    hzx = m_memread && (m_wr != 0) &&
          ((m_wr == ins[25:21]) || ((m_wr == ins[20:16]) && ut));
    st  = hzx && !fl;
    @(negedge clk);
    check_val("stall", {31'b0, stall}, {31'b0, st});
    check_val("r1r2", {22'b0, r1, r2}, {22'b0, ins[25:21], ins[20:16]});
    e = (st || fl) ? exp_t'('0) : model_dec(ins, p4, rd1, rd2, wre, ww, wd);
    exp_q.push_back(e);
    m_memread = e.ctrl[8];
    m_wr      = e.regs[4:0];
    if (st && m_cnt < CMAX) m_cnt++;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    got.ctrl = {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
                ex_branch, ex_jump, ex_aluop};
    got.regs = {ex_rs, ex_rt, ex_wr};
    check_val("ctrl", {22'b0, got.ctrl}, {22'b0, e.ctrl});
    check_val("ex_a", ex_a, e.a);
    check_val("ex_b", ex_b, e.b);
    check_val("ex_imm", ex_imm, e.imm);
    check_val("regs", {17'b0, got.regs}, {17'b0, e.regs});
    check_val("ex_pc4", ex_pc4, e.pc4);
    check_val("stall_count", {28'b0, stall_count}, m_cnt[31:0]);
  endtask

  localparam logic [31:0] I_LW   = 32'h8C220000; // lw   $2,0($1)
  localparam logic [31:0] I_ADD  = 32'h00441820; // add  $3,$2,$4
  localparam logic [31:0] I_ADDB = 32'h00642820; // add  $5,$3,$4
  localparam logic [31:0] I_SW   = 32'hACA20000; // sw   $2,0($5)
  localparam logic [31:0] I_ADDI2= 32'h20A20001; // addi $2,$5,1

  initial begin
    m_memread = 0; m_wr = 0; m_cnt = 0;
    rst = 1; instr = I_LW; pc4 = 32'h4; flush = 0;
    rdata1 = 32'hA5A5A5A5; rdata2 = 32'h5A5A5A5A;
    wb_regwrite = 0; wb_w = 0; wb_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ctrl", {22'b0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
              ex_alusrc, ex_branch, ex_jump, ex_aluop}, 32'h0);
    check_val("rst_data", ex_a | ex_b | ex_imm | ex_pc4, 32'h0);
    check_val("rst_regs", {17'b0, ex_rs, ex_rt, ex_wr}, 32'h0);
    check_val("rst_stall", {31'b0, stall}, 32'h0);
    check_val("rst_cnt", {28'b0, stall_count}, 32'h0);
    rst = 0;

    step(32'h20010005, 32'h104, 32'h1, 32'h2, 0, 0, 0, 0);       // addi $1,$0,5
    step(32'h2001FFFF, 32'h108, 32'h1, 32'h2, 0, 0, 0, 0);       // imm sign-extend
    step(I_ADDB, 32'h10C, 32'h11, 32'h22, 1, 5'd3, 32'h99, 0);   // bypass A
    step(I_ADDB, 32'h110, 32'h11, 32'h22, 1, 5'd0, 32'h99, 0);   // $0 never bypassed
    step(I_ADDB, 32'h114, 32'h11, 32'h22, 1, 5'd4, 32'h77, 0);   // bypass B
    step(I_ADDB, 32'h118, 32'h11, 32'h22, 0, 5'd3, 32'h99, 0);   // no write enable
    step(I_LW,   32'h11C, 32'h30, 32'h31, 0, 0, 0, 0);
    step(I_ADD,  32'h120, 32'h40, 32'h41, 0, 0, 0, 0);           // stall, bubble
    step(I_ADD,  32'h120, 32'h40, 32'h41, 0, 0, 0, 0);           // add proceeds
    step(I_LW,   32'h124, 32'h30, 32'h31, 0, 0, 0, 0);
    step(I_SW,   32'h128, 32'h50, 32'h51, 0, 0, 0, 0);           // hazard via rt
    step(I_SW,   32'h128, 32'h50, 32'h51, 0, 0, 0, 0);
    step(I_LW,   32'h12C, 32'h30, 32'h31, 0, 0, 0, 0);
    step(I_ADDI2,32'h130, 32'h60, 32'h61, 0, 0, 0, 0);           // rt not a source
    step(I_LW,   32'h134, 32'h30, 32'h31, 0, 0, 0, 0);
    step(I_ADD,  32'h138, 32'h40, 32'h41, 0, 0, 0, 1);           // flush beats stall
    step(I_ADD,  32'h13C, 32'h40, 32'h41, 0, 0, 0, 0);
    step(32'h10430004, 32'h140, 32'h7, 32'h8, 0, 0, 0, 0);       // beq $2,$3
    step(32'h08000010, 32'h144, 32'h7, 32'h8, 0, 0, 0, 0);       // j
    step(32'h2862FFF0, 32'h148, 32'h7, 32'h8, 0, 0, 0, 0);       // slti $2,$3,-16
    step(32'hFC221234, 32'h14C, 32'h7, 32'h8, 0, 0, 0, 0);       // unknown opcode
    step(32'h00000000, 32'h150, 32'h7, 32'h8, 0, 0, 0, 0);       // nop

    for (int i = 0; i < CMAX + 4; i++) begin
      step(I_LW,  32'h200, 32'h1, 32'h2, 0, 0, 0, 0);
      step(I_ADD, 32'h204, 32'h3, 32'h4, 0, 0, 0, 0);
      step(I_ADD, 32'h204, 32'h3, 32'h4, 0, 0, 0, 0);
    end

    // Reset arriving while a stall is asserted
    step(I_LW, 32'h300, 32'h1, 32'h2, 0, 0, 0, 0);
    instr = I_ADD; flush = 0;
    @(negedge clk);
    check_val("stall_pre_rst", {31'b0, stall}, 32'h1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check_val("stall_post_rst", {31'b0, stall}, 32'h0);
    check_val("cnt_post_rst", {28'b0, stall_count}, 32'h0);
    check_val("memread_post_rst", {31'b0, ex_memread}, 32'h0);
    m_memread = 0; m_wr = 0; m_cnt = 0;
    step(I_LW,  32'h304, 32'h1, 32'h2, 0, 0, 0, 0);
    step(I_ADD, 32'h308, 32'h3, 32'h4, 0, 0, 0, 0);
    step(I_ADD, 32'h308, 32'h3, 32'h4, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_id_ex_stage
`default_nettype wire
